// File: rtl/vexec_if.sv
// vexec_if: E-stage operand/control bundle and result/stall return path for vexec_seq.
interface vexec_if #(parameter int V = 128, parameter int N = 32, parameter int M = 4);
  logic         start, flush_E, vect_E, imm_sel;
  logic [M-1:0] ALUctrl_E;
  logic [N-1:0] inm_E;
  logic [V-1:0] regA_E, regB_E;
  logic         stall_E;
  logic [V-1:0] result;
  logic         result_valid, zero;
  modport master(output start, flush_E, vect_E, imm_sel, ALUctrl_E, inm_E, regA_E, regB_E,
                 input stall_E, result, result_valid, zero);
  modport slave(input start, flush_E, vect_E, imm_sel, ALUctrl_E, inm_E, regA_E, regB_E,
                output stall_E, result, result_valid, zero);
endinterface

// File: rtl/vexec_seq.sv
// vexec_seq: lane-serial vector execute sequencer, one N-bit ALU lane per cycle.
module vexec_seq #(parameter int V = 128, parameter int N = 32, parameter int M = 4) (
  input logic   clk,
  input logic   rst,
  vexec_if.slave bus
);
  localparam int L  = V / N;
  localparam int S  = $clog2(N);
  localparam int KW = (L > 1) ? $clog2(L) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       r_state, w_next;
  logic [KW-1:0] r_k;
  logic [V-1:0] r_a, r_b, r_acc, w_acc;
  logic [M-1:0] r_ctrl;
  logic         r_vect, r_valid, r_zero;
  logic [N-1:0] w_la, w_lb, w_lane;
  logic         w_last, w_fin;
  always_comb begin
    w_la   = r_a[int'(r_k)*N +: N];
    w_lb   = r_b[int'(r_k)*N +: N];
    w_lane = r_ctrl == M'(0) ? w_la + w_lb :
             r_ctrl == M'(1) ? w_la - w_lb :
             r_ctrl == M'(2) ? w_la & w_lb :
             r_ctrl == M'(3) ? w_la | w_lb :
             r_ctrl == M'(4) ? w_la ^ w_lb :
             r_ctrl == M'(5) ? w_la << w_lb[S-1:0] :
             r_ctrl == M'(6) ? w_la >> w_lb[S-1:0] :
             r_ctrl == M'(7) ? N'(w_la * w_lb) :
             r_ctrl == M'(8) ? w_lb : '0;
    w_acc = r_acc;
    w_acc[int'(r_k)*N +: N] = w_lane;
    w_last = r_vect ? (r_k == KW'(L - 1)) : 1'b1;
    w_fin  = r_state == RUN && w_last && !bus.flush_E;
  end
  // flush wins over everything except reset; DONE always returns to IDLE
  always_comb begin
    w_next = bus.flush_E ? IDLE :
             r_state == IDLE ? (bus.start ? RUN : IDLE) :
             r_state == RUN ? (w_last ? DONE : RUN) : IDLE;
    bus.stall_E = rst && !bus.flush_E && ((r_state == IDLE && bus.start) || r_state == RUN);
    bus.result       = r_acc;
    bus.result_valid = r_valid;
    bus.zero         = r_zero;
  end
  always_ff @(posedge clk)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= '0;
      r_vect  <= 1'b0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_valid <= w_fin;
      r_zero  <= w_fin && w_acc == '0;
      if (r_state == IDLE && bus.start && !bus.flush_E) begin
        r_a    <= bus.regA_E;
        r_b    <= bus.imm_sel ? {L{bus.inm_E}} : bus.regB_E;
        r_ctrl <= bus.ALUctrl_E;
        r_vect <= bus.vect_E;
        r_acc  <= '0;
        r_k    <= '0;
      end else if (r_state == RUN) begin
        r_acc <= bus.flush_E ? '0 : w_acc;
        r_k   <= (bus.flush_E || w_last) ? '0 : r_k + 1'b1;
      end
    end
  end
endmodule
